// File: rtl/sram_arb_512x56_if.sv
// Bus bundle for sram_arb_512x56: two requester ports, the clear/init pair and
// the single-port SRAM macro pins. The arbiter uses the slave modport; the
// environment (requesters plus SRAM) uses the master modport.
interface sram_arb_512x56_if;
  logic        clear;
  logic        init_done;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [8:0]  addr0;
  logic [8:0]  addr1;
  logic [55:0] wdata0;
  logic [55:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [55:0] rdata0;
  logic [55:0] rdata1;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [55:0] mem_din;
  logic [55:0] mem_dout;

  modport slave (
    input  clear, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output init_done, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_we, mem_addr, mem_din
  );

  modport master (
    output clear, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  init_done, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sram_arb_512x56.sv
// Two-port round-robin arbiter and sequencer for the 512x56 single-port SRAM.
// Grants are combinational on req; read data is captured the cycle after the
// access and announced with a one-cycle rvalid pulse.
// Optional macro SRAM_ARB_CLEAR_EN adds a zero sweep of the whole array after
// reset and on each clear pulse sampled while serving.
module sram_arb_512x56 (
  input logic              clk,
  input logic              resetn,
  sram_arb_512x56_if.slave bus
);

`ifdef SRAM_ARB_CLEAR_EN
  typedef enum logic [1:0] {StInit = 2'd0, StClear = 2'd1, StServe = 2'd2} state_e;
  logic [8:0] cnt_q;
`else
  typedef enum logic [1:0] {StInit = 2'd0, StServe = 2'd2} state_e;
  logic       unused_clear;
  assign unused_clear = bus.clear;
`endif

  state_e      state_q;
  logic        init_done_q;
  logic        last_q;      // 1: port 1 was granted most recently
  logic        gnt0, gnt1;
  logic        rd_vld_q;    // a read was granted last cycle
  logic        rd_port_q;   // which port that read belongs to
  logic        rvalid0_q, rvalid1_q;
  logic [55:0] rdata0_q, rdata1_q;

  // Arbitration: single requester wins outright, ties go to the port not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StServe) begin
      if (bus.req0 && bus.req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  // SRAM pin mux: sweep counter while clearing, else the granted port, else idle zeros.
  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = 9'd0;
    bus.mem_din  = 56'd0;
    if (gnt0) begin
      bus.mem_we   = bus.we0;
      bus.mem_addr = bus.addr0;
      bus.mem_din  = bus.wdata0;
    end else if (gnt1) begin
      bus.mem_we   = bus.we1;
      bus.mem_addr = bus.addr1;
      bus.mem_din  = bus.wdata1;
    end
`ifdef SRAM_ARB_CLEAR_EN
    if (state_q == StClear) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = cnt_q;
    end
`endif
  end

  // Control FSM with registered init_done, round-robin pointer and sweep counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StInit;
      init_done_q <= 1'b0;
      last_q      <= 1'b1;
`ifdef SRAM_ARB_CLEAR_EN
      cnt_q       <= 9'd0;
`endif
    end else begin
      if (gnt0) begin
        last_q <= 1'b0;
      end else if (gnt1) begin
        last_q <= 1'b1;
      end
      case (state_q)
        StInit: begin
`ifdef SRAM_ARB_CLEAR_EN
          state_q <= StClear;
          cnt_q   <= 9'd0;
`else
          state_q     <= StServe;
          init_done_q <= 1'b1;
`endif
        end
`ifdef SRAM_ARB_CLEAR_EN
        StClear: begin
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) begin
            state_q     <= StServe;
            init_done_q <= 1'b1;
          end
        end
`endif
        StServe: begin
`ifdef SRAM_ARB_CLEAR_EN
          if (bus.clear) begin
            state_q     <= StClear;
            init_done_q <= 1'b0;
            cnt_q       <= 9'd0;
          end
`endif
        end
        default: begin
          state_q     <= StInit;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline: tag at grant, capture mem_dout one cycle later, pulse rvalid after.
  // Runs independently of the FSM so a read granted alongside clear still completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_vld_q  <= 1'b0;
      rd_port_q <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 56'd0;
      rdata1_q  <= 56'd0;
    end else begin
      rd_vld_q  <= (gnt0 && !bus.we0) || (gnt1 && !bus.we1);
      rd_port_q <= gnt1;
      rvalid0_q <= rd_vld_q && !rd_port_q;
      rvalid1_q <= rd_vld_q && rd_port_q;
      if (rd_vld_q) begin
        if (rd_port_q) begin
          rdata1_q <= bus.mem_dout;
        end else begin
          rdata0_q <= bus.mem_dout;
        end
      end
    end
  end

  assign bus.init_done = init_done_q;
  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule
